// File: rtl/dcm_reset_sequencer.sv
// -----------------------------------------------------------------------------
// dcm_reset_sequencer
//
// Purpose:
//   Sequences a DCM out of reset. It pulses the DCM reset, waits for LOCKED
//   with a timeout-and-retry loop, then holds the system reset for a fixed
//   time after a stable lock before releasing it.
//
// Parameters:
//   RST_CYCLES   - DCM reset pulse width in clk_i cycles      (3..255)
//   LOCK_TIMEOUT - clk_i cycles to wait for lock per attempt  (16..65535)
//   HOLD_CYCLES  - sys_rst_o hold time after lock             (1..255)
//
// Ports:
//   clk_i       in   reference clock (DCM input side), the only clock
//   rst_n_i     in   asynchronous active-low reset
//   locked_i    in   DCM LOCKED, asynchronous to clk_i
//   dcm_rst_o   out  DCM RST, active-high
//   sys_rst_o   out  reset for DCM-output-clocked logic, active-high
//   ready_o     out  high while the sequencer is in RUN
//   retry_cnt_o out  lock timeouts since reset, saturating at 15
//   lock_lost_o out  one-cycle pulse when lock falls while in RUN
//
// Build option:
//   DCM_MONITOR_RELOCK_EN - when defined, a lock loss in RUN restarts the
//   whole sequence; otherwise it is only reported on lock_lost_o.
// -----------------------------------------------------------------------------
module dcm_reset_sequencer #(
    parameter int unsigned RST_CYCLES   = 3,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned HOLD_CYCLES  = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       locked_i,
    output logic       dcm_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic [3:0] retry_cnt_o,
    output logic       lock_lost_o
);

    localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_DCM_RST,
        S_WAIT_LOCK,
        S_HOLD,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_sync1;
    logic        r_lock_s;
    logic        r_lock_prev;
    logic        w_lock_fall;
    logic        w_retry_inc;
    logic        r_dcm_rst;
    logic        r_sys_rst;
    logic        r_ready;
    logic [3:0]  r_retry;
    logic        r_lock_lost;

    assign w_lock_fall = r_lock_prev & ~r_lock_s;

    // Next state and shared counter. Every state transition reloads the
    // counter with the duration of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_inc = 1'b0;
        case (r_state)
            S_DCM_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = WAIT_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a simultaneous timeout.
                if (r_lock_s) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DCM_RST;
                    w_cnt_nxt   = RST_LOAD;
                    w_retry_inc = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end
            S_HOLD: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_DCM_RST;
                    w_cnt_nxt   = RST_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end
            S_RUN: begin
`ifdef DCM_MONITOR_RELOCK_EN
                if (w_lock_fall) begin
                    w_state_nxt = S_DCM_RST;
                    w_cnt_nxt   = RST_LOAD;
                end
`endif
            end
            default: begin
                w_state_nxt = S_DCM_RST;
                w_cnt_nxt   = RST_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register instead of lagging it by a cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_DCM_RST;
            r_cnt       <= RST_LOAD;
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_lock_prev <= 1'b0;
            r_dcm_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync1     <= locked_i;
            r_lock_s    <= r_sync1;
            r_lock_prev <= r_lock_s;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dcm_rst   <= (w_state_nxt == S_DCM_RST);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_lock_lost <= (r_state == S_RUN) && w_lock_fall;
            if (w_retry_inc && (r_retry != 4'hF)) begin
                r_retry <= r_retry + 4'd1;
            end
        end
    end

    assign dcm_rst_o   = r_dcm_rst;
    assign sys_rst_o   = r_sys_rst;
    assign ready_o     = r_ready;
    assign retry_cnt_o = r_retry;
    assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dcm_reset_sequencer
//
// Self-checking bench. dut_a uses default parameters; dut_b uses
// LOCK_TIMEOUT=16 for the timeout/retry scenarios. Expected values are pushed
// to a scoreboard queue and popped when the corresponding observation is made.
// -----------------------------------------------------------------------------
module tb_dcm_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_locked, a_dcm_rst, a_sys_rst, a_ready, a_lost;
    logic [3:0] a_retry;
    logic       b_rst_n, b_locked, b_dcm_rst, b_sys_rst, b_ready, b_lost;
    logic [3:0] b_retry;

    dcm_reset_sequencer dut_a (
        .clk_i       (clk),
        .rst_n_i     (a_rst_n),
        .locked_i    (a_locked),
        .dcm_rst_o   (a_dcm_rst),
        .sys_rst_o   (a_sys_rst),
        .ready_o     (a_ready),
        .retry_cnt_o (a_retry),
        .lock_lost_o (a_lost)
    );

    dcm_reset_sequencer #(.LOCK_TIMEOUT(16)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (b_rst_n),
        .locked_i    (b_locked),
        .dcm_rst_o   (b_dcm_rst),
        .sys_rst_o   (b_sys_rst),
        .ready_o     (b_ready),
        .retry_cnt_o (b_retry),
        .lock_lost_o (b_lost)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string tag_q[$];
    int    exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 1);
        end else begin
            check(tag_q.pop_front(), obs, 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p, input logic d, input logic s, input logic r,
                             input logic [3:0] c, input logic l);
        sb_push({p, "_rst_dcm"}, 1);   sb_pop(32'(d));
        sb_push({p, "_rst_sys"}, 1);   sb_pop(32'(s));
        sb_push({p, "_rst_ready"}, 0); sb_pop(32'(r));
        sb_push({p, "_rst_retry"}, 0); sb_pop(32'(c));
        sb_push({p, "_rst_lost"}, 0);  sb_pop(32'(l));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int prev_dcm;
        int last_rise;
        int rises;

        a_rst_n = 1'b0; a_locked = 1'b0;
        b_rst_n = 1'b0; b_locked = 1'b0;
        #12;
        chk_reset("a", a_dcm_rst, a_sys_rst, a_ready, a_retry, a_lost);
        chk_reset("b", b_dcm_rst, b_sys_rst, b_ready, b_retry, b_lost);

        // ---- A1: default power-up, lock 10 cycles after release ----
        tick();
        a_rst_n = 1'b1;
        sb_push("a_dcm_width", 3);
        w = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_dcm_rst) w++; else break;
        end
        sb_pop(32'(w));
        repeat (7) tick();
        a_locked = 1'b1;
        // two synchronizer cycles, then HOLD_CYCLES+1
        sb_push("a_sys_fall", 2 + 16 + 1);
        w = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            w++;
            if (!a_sys_rst) break;
        end
        sb_pop(32'(w));
        sb_push("a_ready", 1);    sb_pop(32'(a_ready));
        sb_push("a_run_dcm", 0);  sb_pop(32'(a_dcm_rst));
        sb_push("a_run_retry", 0); sb_pop(32'(a_retry));

        // ---- A2: lock lost while in RUN ----
        a_locked = 1'b0;
        sb_push("a_lost_lat", 3);
        w = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            w++;
            if (a_lost) break;
        end
        sb_pop(32'(w));
`ifdef DCM_MONITOR_RELOCK_EN
        sb_push("a_lost_sys", 1);  sb_pop(32'(a_sys_rst));
        sb_push("a_lost_dcm", 1);  sb_pop(32'(a_dcm_rst));
`else
        sb_push("a_lost_sys", 0);   sb_pop(32'(a_sys_rst));
        sb_push("a_lost_ready", 1); sb_pop(32'(a_ready));
`endif
        tick();
        sb_push("a_lost_pulse", 0); sb_pop(32'(a_lost));
        a_locked = 1'b1;
`ifdef DCM_MONITOR_RELOCK_EN
        sb_push("a_rerun_sys_fall", 2 + 16 + 1);
        w = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            w++;
            if (!a_sys_rst) break;
        end
        sb_pop(32'(w));
`else
        repeat (5) tick();
        sb_push("a_norelock_sys", 0); sb_pop(32'(a_sys_rst));
`endif
        sb_push("a_after_ready", 1); sb_pop(32'(a_ready));

        // ---- A3: lock glitch during HOLD ----
        a_locked = 1'b0;
        a_rst_n  = 1'b0;
        tick();
        a_rst_n = 1'b1;
        repeat (10) tick();
        a_locked = 1'b1;
        repeat (6) tick();
        sb_push("a_hold_sys", 1); sb_pop(32'(a_sys_rst));
        a_locked = 1'b0;
        sb_push("a_glitch_dcm_lat", 3);
        w = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            w++;
            if (a_dcm_rst) break;
        end
        sb_pop(32'(w));
        a_locked = 1'b1;
        sb_push("a_glitch_retry", 0); sb_pop(32'(a_retry));
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_ready) break;
        end
        sb_push("a_glitch_ready", 1);  sb_pop(32'(a_ready));
        sb_push("a_glitch_retry2", 0); sb_pop(32'(a_retry));

        // ---- B1: no lock, timeout retries every 19 cycles, saturation ----
        tick();
        b_rst_n   = 1'b1;
        prev_dcm  = 1;
        last_rise = 0;
        rises     = 0;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (b_dcm_rst && (prev_dcm == 0)) begin
                rises++;
                sb_push("b_period", 19);
                sb_pop(32'(e - last_rise));
                sb_push("b_retry_count", (rises > 15) ? 15 : rises);
                sb_pop(32'(b_retry));
                last_rise = e;
            end
            prev_dcm = b_dcm_rst ? 1 : 0;
            if (e == 100) begin
                sb_push("b_rises_100", 5);
                sb_pop(32'(rises));
            end
        end
        sb_push("b_retry_sat", 15); sb_pop(32'(b_retry));

        // ---- B2: lock_s arrives in the cycle the timeout reaches 0 ----
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        repeat (16) tick();
        b_locked = 1'b1;
        repeat (3) tick();
        sb_push("b_tie_dcm", 0);   sb_pop(32'(b_dcm_rst));
        sb_push("b_tie_retry", 0); sb_pop(32'(b_retry));
        sb_push("b_tie_sys", 1);   sb_pop(32'(b_sys_rst));
        sb_push("b_tie_sys_fall", 16);
        w = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            w++;
            if (!b_sys_rst) break;
        end
        sb_pop(32'(w));

        // ---- B3: lock one cycle too late -> timeout counted ----
        b_locked = 1'b0;
        b_rst_n  = 1'b0;
        tick();
        b_rst_n = 1'b1;
        repeat (17) tick();
        b_locked = 1'b1;
        repeat (2) tick();
        sb_push("b_late_dcm", 1);   sb_pop(32'(b_dcm_rst));
        sb_push("b_late_retry", 1); sb_pop(32'(b_retry));

        // ---- B4: reset pulsed during WAIT_LOCK with retry_cnt_o=2 ----
        b_locked = 1'b0;
        b_rst_n  = 1'b0;
        tick();
        b_rst_n = 1'b1;
        repeat (45) tick();
        sb_push("b_pre_retry", 2); sb_pop(32'(b_retry));
        sb_push("b_pre_dcm", 0);   sb_pop(32'(b_dcm_rst));
        #1 b_rst_n = 1'b0;
        #1;
        chk_reset("b_mid", b_dcm_rst, b_sys_rst, b_ready, b_retry, b_lost);
        tick();
        b_rst_n = 1'b1;
        sb_push("b_post_dcm_width", 3);
        w = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b_dcm_rst) w++; else break;
        end
        sb_pop(32'(w));

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
